core_ex_div: RTL and testbench
==============================

# core_ex_div

Iterative RV32M divide unit for DIV/DIVU/REM/REMU. It sits directly downstream of the ID/EX pipeline register, in parallel with the single-cycle ALU path. It consumes the decoded opcode/func3/func7/operand/rd fields that ID/EX presents. While a divide is in flight it raises a hold request to core_ctrl so that ID/EX and earlier stages freeze. It then emits a one-cycle register writeback toward the EX/MEM side.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  asynchronous reset.
- Inputs from core_id_ex:
  - opcode_in  in  7  from core_id_ex.
  - func3_in  in  3  from core_id_ex.
  - func7_in  in  7  from core_id_ex.
  - reg1_data_in  in  XLEN  dividend (rs1 value).
  - reg2_data_in  in  XLEN  divisor (rs2 value).
  - reg_write_addr_in  in  5  destination rd.
  - reg_we_in  in  1  writeback enable from decode.
- Input from core_ctrl:
  - flush_in  in  1  abort from core_ctrl (taken jump/branch).
- Outputs:
  - hold_req_out  out  1  stall request to core_ctrl.
  - busy_out  out  1  high in CALC and DONE.
  - result_valid_out  out  1  one-cycle writeback strobe.
  - result_out  out  XLEN  quotient or remainder.
  - reg_write_addr_out  out  5  rd of the completed op.
  - reg_we_out  out  1  write enable.
    - Equals result_valid_out AND the latched reg_we_in AND (rd != 0).

## Operation
- **start** is asserted when all of the following hold:
  - opcode_in == 7'b0110011;
  - func7_in == 7'b0000001;
  - func3_in[2] == 1;
  - state == IDLE;
  - flush_in == 0.
- func3 decoding:
  - 100 = DIV
  - 101 = DIVU
  - 110 = REM
  - 111 = REMU
- **IDLE**
  - On start: latch op, rd, and reg_we. Latch |dividend| and |divisor| (signed ops) or the raw values (unsigned). Record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
  - Divisor == 0: go to DONE with these results:
    - quotient = all-ones;
    - remainder = dividend, unchanged.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: go to DONE with these results:
    - quotient = 0x80000000;
    - remainder = 0.
  - Otherwise: clear the partial remainder and counter, then go to CALC.
- **CALC**: restoring division, one quotient bit per cycle, MSB first.
  - Shift: rem = {rem[XLEN-2:0], dvd[XLEN-1]}; dvd <<= 1.
  - Trial: if rem >= divisor, then rem -= divisor and the quotient bit is 1.
  - Widths:
    - the trial subtract is XLEN+1 bits;
    - the counter is $clog2(XLEN) bits;
    - the counter wraps from XLEN-1 to 0 on exit.
  - After XLEN iterations (counter == XLEN-1), go to DONE.
- **DONE**
  - Apply the sign fixes (two's-complement negate):
    - quotient when the quotient sign = 1;
    - remainder when the remainder sign = 1.
  - result_out = quotient for DIV/DIVU, remainder for REM/REMU.
  - Assert result_valid_out for exactly one cycle, then go unconditionally to IDLE.
  - The start condition is ignored in DONE, because ID/EX still presents the same instruction that cycle.
- **hold_req_out** = start OR (state == CALC), gated to 0 whenever flush_in = 1. It is combinational, so ID/EX holds on the start cycle itself.
- **flush_in**, in any state:
  - next state is IDLE;
  - no result_valid_out follows;
  - hold_req_out drops in the same cycle.
  - A flush in DONE suppresses result_valid_out; the registered strobe is gated by !flush_in.
- **Reset**, asynchronous and possibly mid-operation, clears all of the following immediately:
  - state = IDLE;
  - counter and datapath registers = 0;
  - hold_req_out = 0, busy_out = 0, result_valid_out = 0;
  - result_out = 0, reg_write_addr_out = 0, reg_we_out = 0.
- Outside DONE, result_out and reg_write_addr_out read 0.

## Timing
- Normal op, start seen in cycle T:
  - CALC covers cycles T+1..T+XLEN (32 cycles);
  - DONE and result_valid_out in cycle T+XLEN+1 (T+33);
  - IDLE at T+34.
- hold_req_out is high in cycles T..T+32 (33 cycles) and low in T+33. At the T+33→T+34 edge, ID/EX loads the next instruction.
- Special cases (divide by zero, signed overflow): result in T+1, hold high in T only, total 2 cycles.
- Back-to-back divides: the second start can occur no earlier than T+34.
- Writeback latency is measured from the end of the hold; the result is registered, with no combinational path from reg*_data_in to result_out.

## Test plan
- **DIVU**: 100 / 7, rd=5, issued at T → hold high T..T+32; at T+33 result_valid_out=1, result_out=14, reg_write_addr_out=5, reg_we_out=1.
- **REM/DIV signed**:
  - REM -7 (0xFFFFFFF9) % 2 → 0xFFFFFFFF at T+33;
  - DIV -7 / 2 → 0xFFFFFFFD;
  - REMU 0xFFFFFFF9 % 2 → 1.
- **Divide by zero**:
  - DIV 123 / 0 → 0xFFFFFFFF at T+1;
  - REM 123 % 0 → 123;
  - hold high for one cycle only.
- **Signed overflow**:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1;
  - REM of the same operands → 0.
- **Abort cases**:
  - flush_in pulse at T+10 → state IDLE, hold_req_out=0 that cycle, no result_valid_out ever.
  - rst asserted at T+20 → all outputs 0 immediately; a subsequent DIVU 9/3 completes normally with result 3.
- **Non-writing cases**:
  - rd=0 → result_valid_out=1 with reg_we_out=0.
  - Non-M opcode (ADD, func7=0) → hold_req_out never asserts.

Source files
------------

// File: rtl/core_ex_div.sv
// -----------------------------------------------------------------------------
// core_ex_div
//
// Iterative RV32M divide unit (DIV / DIVU / REM / REMU) placed beside the
// single-cycle ALU, directly after the ID/EX pipeline register. A divide is
// recognised combinationally from the decoded ID/EX fields. While it is in
// flight the unit requests a pipeline hold from core_ctrl. It then emits a
// one-cycle writeback strobe toward EX/MEM.
//
// Algorithm: restoring division, one quotient bit per clock, MSB first, on
// operand magnitudes. The sign correction is applied when the result is
// presented. Divide-by-zero and signed overflow skip the iteration and
// finish in the cycle after start.
//
// Ports
//   clk                 in   clock
//   rst                 in   asynchronous reset, active high
//   opcode_in           in   [6:0]      opcode from ID/EX
//   func3_in            in   [2:0]      func3 from ID/EX (100 DIV, 101 DIVU,
//                                       110 REM, 111 REMU)
//   func7_in            in   [6:0]      func7 from ID/EX
//   reg1_data_in        in   [XLEN-1:0] dividend (rs1)
//   reg2_data_in        in   [XLEN-1:0] divisor  (rs2)
//   reg_write_addr_in   in   [4:0]      destination rd
//   reg_we_in           in   writeback enable from decode
//   flush_in            in   abort from core_ctrl (taken branch/jump)
//   hold_req_out        out  stall request to core_ctrl (combinational)
//   busy_out            out  high while calculating or presenting a result
//   result_valid_out    out  one-cycle writeback strobe
//   result_out          out  [XLEN-1:0] quotient or remainder (0 when idle)
//   reg_write_addr_out  out  [4:0]      rd of the completed op (0 when idle)
//   reg_we_out          out  register-file write enable for the result
// -----------------------------------------------------------------------------
module core_ex_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode_in,
    input  logic [2:0]      func3_in,
    input  logic [6:0]      func7_in,
    input  logic [XLEN-1:0] reg1_data_in,
    input  logic [XLEN-1:0] reg2_data_in,
    input  logic [4:0]      reg_write_addr_in,
    input  logic            reg_we_in,
    input  logic            flush_in,
    output logic            hold_req_out,
    output logic            busy_out,
    output logic            result_valid_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      reg_write_addr_out,
    output logic            reg_we_out
);

    localparam int CW = $clog2(XLEN);

    localparam logic [6:0]      OPC_OP   = 7'b0110011;
    localparam logic [6:0]      F7_MEXT  = 7'b0000001;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    // dvd_q holds the dividend magnitude. Quotient bits shift into its LSB as
    // dividend bits leave the MSB, so it holds the quotient magnitude at DONE.
    logic [XLEN-1:0] dvd_q,   dvd_d;
    logic [XLEN-1:0] dvs_q,   dvs_d;
    logic [XLEN-1:0] rem_q,   rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            sel_rem_q, sel_rem_d;
    logic [4:0]      rd_q,    rd_d;
    logic            we_q,    we_d;

    // -------------------------------------------------------------------------
    // Decode of the instruction currently presented by ID/EX
    // -------------------------------------------------------------------------
    logic            is_mdiv;
    logic            start;
    logic            is_signed;
    logic            sign1, sign2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero;
    logic            sgn_ovf;

    assign is_mdiv   = (opcode_in == OPC_OP) && (func7_in == F7_MEXT) && func3_in[2];
    // While reset is applied the unit must look idle, so start is masked too.
    assign start     = is_mdiv && (state_q == S_IDLE) && !flush_in && !rst;
    assign is_signed = !func3_in[0];

    assign sign1     = is_signed && reg1_data_in[XLEN-1];
    assign sign2     = is_signed && reg2_data_in[XLEN-1];
    assign abs1      = sign1 ? (~reg1_data_in + 1'b1) : reg1_data_in;
    assign abs2      = sign2 ? (~reg2_data_in + 1'b1) : reg2_data_in;

    assign div_zero  = (reg2_data_in == '0);
    assign sgn_ovf   = is_signed && (reg1_data_in == MOST_NEG) && (reg2_data_in == '1);

    // -------------------------------------------------------------------------
    // One restoring-division step
    // -------------------------------------------------------------------------
    // The shifted partial remainder needs XLEN+1 bits. With a divisor above
    // 2^(XLEN-1), twice the previous remainder can exceed XLEN bits.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            q_bit;

    assign rem_shift = {rem_q, dvd_q[XLEN-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign q_bit     = !trial[XLEN];

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first. Any
        // path that leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        rd_d      = rd_q;
        we_d      = we_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_rem_d = func3_in[1];
                    rd_d      = reg_write_addr_in;
                    we_d      = reg_we_in;
                    dvs_d     = abs2;
                    cnt_d     = '0;
                    if (div_zero || sgn_ovf) begin
                        // Architecturally defined results are loaded as final
                        // values, so the sign fix-up is switched off for them.
                        dvd_d   = div_zero ? '1 : MOST_NEG;
                        rem_d   = div_zero ? reg1_data_in : '0;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        dvd_d   = abs1;
                        rem_d   = '0;
                        q_neg_d = sign1 ^ sign2;
                        r_neg_d = sign1;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                rem_d = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
                dvd_d = {dvd_q[XLEN-2:0], q_bit};
                // The counter wraps back to zero on the final iteration.
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // ID/EX still presents the same divide here, so start is not
                // looked at. Return to IDLE unconditionally.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An abort from core_ctrl wins over everything above.
        if (flush_in) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples pre-edge values, whatever the statement order.
    // NOTE: the datapath registers are reset as well as the control state.
    // A reset in the middle of an operation leaves no stale operand, sign or
    // rd behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            rd_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // All result logic is driven from registers only. No combinational path
    // runs from the operand inputs to result_out.
    logic            in_done;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign in_done = (state_q == S_DONE);
    assign quo_fix = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
    assign rem_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;

    // The hold covers the start cycle itself, so ID/EX freezes on the very
    // instruction being consumed. It drops during DONE, so ID/EX loads the
    // next instruction on the DONE->IDLE edge.
    assign hold_req_out       = (start || (state_q == S_CALC)) && !flush_in;
    assign busy_out           = (state_q == S_CALC) || in_done;
    assign result_valid_out   = in_done && !flush_in;
    assign result_out         = in_done ? (sel_rem_q ? rem_fix : quo_fix) : '0;
    assign reg_write_addr_out = in_done ? rd_q : 5'd0;
    assign reg_we_out         = result_valid_out && we_q && (rd_q != 5'd0);

endmodule

// File: tb/tb_core_ex_div.sv
// -----------------------------------------------------------------------------
// tb_core_ex_div
//
// Self-checking bench for core_ex_div. It runs directed cases and then
// randomised divides. Each result is compared with a reference model. The
// model uses SystemVerilog integer division plus the RISC-V rules for the
// architecturally defined special cases.
// -----------------------------------------------------------------------------
module tb_core_ex_div;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      opcode_in;
    logic [2:0]      func3_in;
    logic [6:0]      func7_in;
    logic [XLEN-1:0] reg1_data_in;
    logic [XLEN-1:0] reg2_data_in;
    logic [4:0]      reg_write_addr_in;
    logic            reg_we_in;
    logic            flush_in;
    logic            hold_req_out;
    logic            busy_out;
    logic            result_valid_out;
    logic [XLEN-1:0] result_out;
    logic [4:0]      reg_write_addr_out;
    logic            reg_we_out;

    int n_cmp = 0;
    int n_bad = 0;

    core_ex_div #(.XLEN(XLEN)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode_in          (opcode_in),
        .func3_in           (func3_in),
        .func7_in           (func7_in),
        .reg1_data_in       (reg1_data_in),
        .reg2_data_in       (reg2_data_in),
        .reg_write_addr_in  (reg_write_addr_in),
        .reg_we_in          (reg_we_in),
        .flush_in           (flush_in),
        .hold_req_out       (hold_req_out),
        .busy_out           (busy_out),
        .result_valid_out   (result_valid_out),
        .result_out         (result_out),
        .reg_write_addr_out (reg_write_addr_out),
        .reg_we_out         (reg_we_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: RISC-V M-extension divide semantics.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        int  sa = int'(a);
        int  sb = int'(b);
        bit  ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic w);
        opcode_in         = op;
        func7_in          = f7;
        func3_in          = f3;
        reg1_data_in      = a;
        reg2_data_in      = b;
        reg_write_addr_in = d;
        reg_we_in         = w;
    endtask

    task automatic drive_nop();
        drive(7'h13, 7'h0, 3'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    // Presents one divide like ID/EX would: held until the hold drops, kept
    // through the result cycle, then replaced by a bubble.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic w);
        logic [31:0] exp_res = model(f3, a, b);
        int          exp_lat = is_special(f3, a, b) ? 1 : XLEN + 1;
        int          hold_cnt;
        int          lat = 0;
        bit          seen = 0;

        @(negedge clk);
        drive(7'b0110011, 7'b0000001, f3, a, b, d, w);
        #1;
        check({tag, "/hold_start"}, {31'b0, hold_req_out}, 32'd1);
        hold_cnt = 1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (result_valid_out) begin
                seen = 1;
                lat  = k;
                check({tag, "/result"}, result_out, exp_res);
                check({tag, "/rd"}, {27'b0, reg_write_addr_out}, {27'b0, d});
                check({tag, "/we"}, {31'b0, reg_we_out}, {31'b0, w && (d != 0)});
                check({tag, "/hold_done"}, {31'b0, hold_req_out}, 32'd0);
            end else if (hold_req_out) begin
                hold_cnt++;
            end
        end
        if (!seen) check({tag, "/valid_timeout"}, 32'd0, 32'd1);
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/hold_cycles"}, hold_cnt, exp_lat);
        @(negedge clk);
        drive_nop();
        #1;
        check({tag, "/one_shot"}, {31'b0, result_valid_out}, 32'd0);
        check({tag, "/idle"}, {31'b0, busy_out}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(1, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int vcount;

        rst      = 1'b1;
        flush_in = 1'b0;
        drive_nop();
        repeat (2) @(negedge clk);
        #1;
        check("reset/hold", {31'b0, hold_req_out}, 32'd0);
        check("reset/busy", {31'b0, busy_out}, 32'd0);
        check("reset/valid", {31'b0, result_valid_out}, 32'd0);
        check("reset/result", result_out, 32'd0);
        rst = 1'b0;

        // Directed cases from the test plan.
        run_op("divu_100_7",   3'b101, 32'd100,        32'd7,          5'd5,  1'b1);
        run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          5'd6,  1'b1);
        run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  1'b1);
        run_op("remu_m7_2",    3'b111, 32'hFFFF_FFF9,  32'd2,          5'd8,  1'b1);
        run_op("div_by_zero",  3'b100, 32'd123,        32'd0,          5'd9,  1'b1);
        run_op("rem_by_zero",  3'b110, 32'd123,        32'd0,          5'd10, 1'b1);
        run_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 1'b1);
        run_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 1'b1);
        run_op("divu_big_dvs", 3'b101, 32'hFFFF_FFFE,  32'h8000_0001,  5'd13, 1'b1);
        run_op("div_rd0",      3'b100, 32'd50,         32'd5,          5'd0,  1'b1);
        run_op("div_no_we",    3'b100, 32'd50,         32'd5,          5'd3,  1'b0);

        // ADD and MUL must never request a hold.
        @(negedge clk);
        vcount = 0;
        drive(7'b0110011, 7'b0000000, 3'b000, 32'd100, 32'd7, 5'd5, 1'b1);
        repeat (3) begin #1; if (hold_req_out || busy_out) vcount++; @(negedge clk); end
        drive(7'b0110011, 7'b0000001, 3'b000, 32'd100, 32'd7, 5'd5, 1'b1);
        repeat (3) begin #1; if (hold_req_out || busy_out) vcount++; @(negedge clk); end
        check("non_div/hold", vcount, 0);
        drive_nop();

        // Flush during CALC: the hold drops at once and no result ever appears.
        @(negedge clk);
        drive(7'b0110011, 7'b0000001, 3'b101, 32'd1000, 32'd3, 5'd4, 1'b1);
        repeat (10) @(negedge clk);
        flush_in = 1'b1;
        #1;
        check("flush_calc/hold", {31'b0, hold_req_out}, 32'd0);
        @(negedge clk);
        flush_in = 1'b0;
        drive_nop();
        #1;
        check("flush_calc/idle", {31'b0, busy_out}, 32'd0);
        vcount = 0;
        repeat (40) begin @(negedge clk); #1; if (result_valid_out) vcount++; end
        check("flush_calc/no_valid", vcount, 0);

        // Flush in the result cycle suppresses the strobe.
        @(negedge clk);
        drive(7'b0110011, 7'b0000001, 3'b100, 32'd77, 32'd5, 5'd4, 1'b1);
        repeat (XLEN + 1) @(negedge clk);
        flush_in = 1'b1;
        #1;
        check("flush_done/busy", {31'b0, busy_out}, 32'd1);
        check("flush_done/valid", {31'b0, result_valid_out}, 32'd0);
        check("flush_done/we", {31'b0, reg_we_out}, 32'd0);
        @(negedge clk);
        flush_in = 1'b0;
        drive_nop();
        #1;
        check("flush_done/after", {31'b0, result_valid_out | busy_out}, 32'd0);

        // Asynchronous reset mid-operation clears all outputs immediately.
        @(negedge clk);
        drive(7'b0110011, 7'b0000001, 3'b101, 32'd500, 32'd7, 5'd9, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid/outs",
              {26'b0, hold_req_out, busy_out, result_valid_out, reg_we_out, 2'b0}, 32'd0);
        check("rst_mid/result", result_out, 32'd0);
        check("rst_mid/rd", {27'b0, reg_write_addr_out}, 32'd0);
        @(negedge clk);
        drive_nop();
        rst = 1'b0;
        run_op("after_rst_divu_9_3", 3'b101, 32'd9, 32'd3, 5'd2, 1'b1);

        // Randomised operations.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3 = 3'($urandom_range(4, 7));
            logic [31:0] a  = pick_operand();
            logic [31:0] b  = pick_operand();
            logic [4:0]  d  = 5'($urandom_range(0, 31));
            logic        w  = ($urandom_range(0, 3) != 0);
            run_op($sformatf("rand%0d", i), f3, a, b, d, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
